// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and burst limit.
// Imported by the arbiter top and its round-robin picker.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHARED = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam int MAX_BURST_DEFAULT = 16;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// port named by the pointer.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a 256x8 asynchronous-read data memory, with a
// bounded burst lock that port 1 can take while port 0 keeps requesting.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       lock1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] burst_sum;
  logic [1:0]       rr_gnt;
  logic             rvalid0_reg, rvalid1_reg;
  logic [7:0]       rdata0_reg, rdata1_reg;

  rr_pick2 u_pick (
    .req ({req1, req0}),
    .ptr (ptr_reg),
    .gnt (rr_gnt)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    if (!rst) begin
      if (state_reg == ST_LOCKED && req1) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = rr_gnt[0];
        gnt1 = rr_gnt[1];
      end
    end

    // Whoever was just served yields the next tie to the other port.
    if (gnt0) begin
      ptr_next = 1'b1;
    end else if (gnt1) begin
      ptr_next = 1'b0;
    end

    burst_sum = cnt_reg + CNT_W'(gnt1 & req0);

    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) state_next = ST_SHARED;
      end
      ST_SHARED: begin
        if (gnt1 && lock1) begin
          state_next = ST_LOCKED;
          cnt_next   = '0;
        end else if (!req0 && !req1) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (!lock1 || !req1 || burst_sum == CNT_W'(MAX_BURST)) begin
          state_next = ST_SHARED;
          cnt_next   = '0;
        end else begin
          cnt_next = burst_sum;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= 1'b0;
      cnt_reg     <= '0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
      rdata0_reg  <= 8'h00;
      rdata1_reg  <= 8'h00;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      rvalid0_reg <= gnt0 & ~we0;
      rvalid1_reg <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0_reg <= mem_rdata;
      if (gnt1 && !we1) rdata1_reg <= mem_rdata;
    end
  end

  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr  = gnt1 ? addr1  : (gnt0 ? addr0  : 8'h00);
  assign mem_wdata = gnt1 ? wdata1 : (gnt0 ? wdata0 : 8'h00);

  // Gated so a reset landing in the response cycle hides the pending read.
  assign rvalid0 = rvalid0_reg & ~rst;
  assign rvalid1 = rvalid1_reg & ~rst;
  assign rdata0  = rst ? 8'h00 : rdata0_reg;
  assign rdata1  = rst ? 8'h00 : rdata1_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd29) ^ 8'h5A;
  endfunction

  // Environment memory driven by the DUT's memory port.
  logic [7:0] env_mem [256];
  bit         env_written [256];
  assign mem_rdata = env_written[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr]     <= mem_wdata;
      env_written[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: arbitration mode, favoured port, waiting-burst count,
  // pending read responses and its own copy of the memory.
  int         m_mode;  // 0 idle, 1 shared, 2 locked
  bit         m_fav;
  int         m_cnt;
  bit         m_rv0, m_rv1;
  logic [7:0] m_rd0, m_rd1;
  logic [7:0] m_mem [256];

  initial begin
    bit         e_g0, e_g1, e_we;
    logic [7:0] e_addr, e_wd;
    int         n_mode, n_cnt, waited;
    bit         n_fav, n_rv0, n_rv1;
    logic [7:0] n_rd0, n_rd1;
    arb_state_t e_state;

    for (int i = 0; i < 256; i++) m_mem[i] = init_val(8'(i));
    m_mode = 0; m_fav = 1'b0; m_cnt = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 8'h00; m_rd1 = 8'h00;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (!rst) begin
        if (m_mode == 2 && req1) e_g1 = 1'b1;
        else if (req0 && req1) begin
          if (m_fav) e_g1 = 1'b1; else e_g0 = 1'b1;
        end else begin
          e_g0 = req0;
          e_g1 = req1;
        end
      end
      e_we   = (e_g0 && we0) || (e_g1 && we1);
      e_addr = e_g0 ? addr0 : (e_g1 ? addr1 : 8'h00);
      e_wd   = e_g0 ? wdata0 : (e_g1 ? wdata1 : 8'h00);
      e_state = (m_mode == 0) ? ST_IDLE : ((m_mode == 1) ? ST_SHARED : ST_LOCKED);

      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("rvalid0", rvalid0, !rst && m_rv0);
      chk("rvalid1", rvalid1, !rst && m_rv1);
      chk("rdata0", rdata0, rst ? 8'h00 : m_rd0);
      chk("rdata1", rdata1, rst ? 8'h00 : m_rd1);
      chk("state", 32'(dut.state_reg), 32'(e_state));
      chk("burst_cnt", 32'(dut.cnt_reg), 32'(m_cnt));

      if (verbose && (e_g0 || e_g1))
        $display("txn t=%0t port=%0d %s addr=%02h wdata=%02h lock1=%0d",
                 $time, e_g1 ? 1 : 0, e_we ? "wr" : "rd", e_addr, e_wd, lock1);

      if (rst) begin
        n_mode = 0; n_fav = 1'b0; n_cnt = 0;
        n_rv0 = 1'b0; n_rv1 = 1'b0; n_rd0 = 8'h00; n_rd1 = 8'h00;
      end else begin
        n_fav = e_g0 ? 1'b1 : (e_g1 ? 1'b0 : m_fav);
        n_rv0 = e_g0 && !we0;
        n_rv1 = e_g1 && !we1;
        n_rd0 = n_rv0 ? m_mem[addr0] : m_rd0;
        n_rd1 = n_rv1 ? m_mem[addr1] : m_rd1;
        n_mode = m_mode;
        n_cnt  = m_cnt;
        case (m_mode)
          0: if (req0 || req1) n_mode = 1;
          1: begin
            if (e_g1 && lock1) begin n_mode = 2; n_cnt = 0; end
            else if (!req0 && !req1) n_mode = 0;
          end
          default: begin
            waited = m_cnt + ((e_g1 && req0) ? 1 : 0);
            if (!lock1 || !req1 || waited >= MAXB) begin n_mode = 1; n_cnt = 0; end
            else n_cnt = waited;
          end
        endcase
      end

      @(posedge clk);
      if (!rst && e_we) m_mem[e_addr] = e_wd;
      m_mode = n_mode; m_fav = n_fav; m_cnt = n_cnt;
      m_rv0 = n_rv0; m_rv1 = n_rv1; m_rd0 = n_rd0; m_rd1 = n_rd1;
    end
  end

  task automatic set_in(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                        input bit l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rdata0", rdata0, 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    next_cyc();
    rst = 1'b0;
    set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    next_cyc();
    do_reset();

    // Port 0 writes 0xA5 to 0x10, then reads it back.
    set_in(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    next_cyc();
    set_in(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("rd_gnt0", gnt0, 1);
    chk("rd_no_rvalid_after_wr", rvalid0, 0);
    next_cyc();
    set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata0", rdata0, 8'hA5);
    next_cyc();
    @(negedge clk);
    chk("rd_rvalid0_drop", rvalid0, 0);
    chk("rd_rdata0_hold", rdata0, 8'hA5);
    next_cyc();

    // Round-robin contention right after reset: 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 8'($urandom), 8'h00, 1, 0, 8'($urandom), 8'h00, 0);
      @(negedge clk);
      chk("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
      next_cyc();
    end

    // Uncontended lock: every cycle granted, counter stays 0.
    do_reset();
    set_in(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lock_gnt1", gnt1, 1);
      chk("lock_cnt", 32'(dut.cnt_reg), 0);
      next_cyc();
    end
    // Port 0 now waits: 16 locked grants, then port 0 on the 17th cycle.
    set_in(1, 0, 8'h41, 8'h00, 1, 0, 8'h40, 8'h00, 1);
    for (int i = 0; i < MAXB; i++) begin
      @(negedge clk);
      chk("burst_gnt1", gnt1, 1);
      chk("burst_gnt0", gnt0, 0);
      next_cyc();
    end
    @(negedge clk);
    chk("burst_release_gnt0", gnt0, 1);
    next_cyc();

    // Reset lands right after a locked read on port 1.
    do_reset();
    set_in(0, 0, 8'h00, 8'h00, 1, 0, 8'h55, 8'h00, 1);
    next_cyc();
    @(negedge clk);
    chk("rstmid_gnt1", gnt1, 1);
    chk("rstmid_locking", 32'(dut.state_reg), 32'(ST_SHARED));
    next_cyc();
    rst = 1'b1;
    set_in(1, 0, 8'h56, 8'h00, 1, 0, 8'h55, 8'h00, 1);
    @(negedge clk);
    chk("rstmid_rvalid1", rvalid1, 0);
    chk("rstmid_ignore_gnt", {30'd0, gnt1, gnt0}, 0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", 32'(dut.state_reg), 32'(ST_IDLE));
    chk("rstmid_gnt0", gnt0, 1);
    next_cyc();

    // Port 1 writes 0x3C to 0xFF, port 0 reads it.
    set_in(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h3C, 0);
    @(negedge clk);
    chk("raw_gnt1", gnt1, 1);
    next_cyc();
    set_in(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("raw_gnt0", gnt0, 1);
    next_cyc();
    set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    chk("raw_rdata0", rdata0, 8'h3C);
    next_cyc();

    // Randomized traffic: mixed, then lock-heavy to reach the burst bound.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        rst = ($urandom % 64) == 0;
        set_in(1'($urandom), 1'($urandom), 8'($urandom % 16), 8'($urandom),
               1'($urandom), 1'($urandom), 8'($urandom % 16), 8'($urandom),
               ($urandom % 4) != 0);
      end else begin
        rst = ($urandom % 200) == 0;
        set_in(($urandom % 10) < 7, 1'($urandom), 8'($urandom % 16), 8'($urandom),
               ($urandom % 20) != 0, 1'($urandom), 8'($urandom % 16), 8'($urandom),
               ($urandom % 40) != 0);
      end
      next_cyc();
    end
    rst = 1'b0;
    set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    next_cyc();
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports req0/req1  input  1 each  access request from port 0 (core) and port 1 (loader/debug).
REQ-004 SHALL have ports we0/we1  input  1 each  write enable; 0 means read.
REQ-005 SHALL have ports addr0/addr1  input  8 each  data memory address.
REQ-006 SHALL have ports wdata0/wdata1  input  8 each  write data.
REQ-007 SHALL have port lock1  input  1  port 1 requests burst ownership.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each  access accepted this cycle.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1 each  read data valid.
REQ-010 SHALL have ports rdata0/rdata1  output  8 each  registered read data.
REQ-011 SHALL have ports mem_we  output  1, mem_addr  output  8, mem_wdata  output  8, all driving the 256x8 data memory.
REQ-012 SHALL have port mem_rdata  input  8  asynchronous memory read data.
REQ-013 SHALL have parameter MAX_BURST, default 16, meaning the maximum consecutive locked grants to port 1 while port 0 waits.

Function
REQ-014 SHALL grant at most one port per cycle; gnt is combinational from req and internal state.
REQ-015 SHALL drive mem_* from the granted port in the grant cycle; mem_we SHALL be 0 when no grant or the grant is a read.
REQ-016 SHALL register mem_rdata on a granted read and assert rvalid of that port for exactly the next cycle; rdata SHALL hold its value until the next read on that port.
REQ-017 SHALL leave rvalid low after a granted write.
REQ-018 Requesters SHALL hold req, we, addr and wdata stable until gnt; the arbiter SHALL NOT depend on this beyond the grant cycle.
REQ-019 SHALL use a 1-bit round-robin pointer: on simultaneous req0 and req1 with no lock, grant the port the pointer favours, then point to the other port.
REQ-020 SHALL grant a single requester immediately regardless of the pointer; the pointer SHALL then favour the other port.
REQ-021 SHALL implement an FSM with states IDLE, SHARED and LOCKED.
REQ-022 IDLE -> SHARED on any req.
REQ-023 SHARED -> LOCKED when port 1 is granted with lock1=1.
REQ-024 SHARED -> IDLE when no req.
REQ-025 In LOCKED, SHALL grant port 1 whenever req1=1, even if req0=1.
REQ-026 In LOCKED, SHALL count grants made while req0=1.
REQ-027 LOCKED -> SHARED when lock1=0, when req1=0, or when the count reaches MAX_BURST; on a count-forced exit, the next contended cycle SHALL grant port 0.
REQ-028 SHALL clear the burst counter on entry to LOCKED and on exit from it.
REQ-029 Write-then-read to the same address on consecutive grants SHALL return the newly written data.

Reset
REQ-030 While rst=1: gnt0, gnt1, rvalid0, rvalid1 and mem_we SHALL be 0.
REQ-031 While rst=1: rdata0, rdata1, mem_addr and mem_wdata SHALL be 0x00.
REQ-032 While rst=1: FSM SHALL be IDLE, pointer SHALL favour port 0, and counter SHALL be 0.
REQ-033 rst asserted during a locked burst or in the cycle after a granted read SHALL cancel the lock and suppress the pending rvalid.
REQ-034 SHALL ignore requests in the reset cycle; normal arbitration SHALL resume in the first cycle with rst=0.

Structure
REQ-035 FSM state encoding and the MAX_BURST default SHALL live in the shared core package.
REQ-036 The round-robin pick SHALL be a sub-module rr_pick2 (inputs: req pair, pointer; output: one-hot grant).

Verification
REQ-037 Bench SHALL cover: single request; req0 only, we0=1, addr0=0x10, wdata0=0xA5, then read 0x10 -> gnt0 both cycles, rvalid0 one cycle later, rdata0=0xA5.
REQ-038 Bench SHALL cover: round-robin contention; req0=req1=1 reads for 4 cycles after reset -> grants 0,1,0,1.
REQ-039 Bench SHALL cover: lock without contention; lock1=1, req1=1 for 5 cycles, req0=0 -> gnt1 every cycle, counter stays 0.
REQ-040 Bench SHALL cover: burst starvation bound; lock1=1 with req0 and req1 held high, MAX_BURST=16 -> 16 gnt1 cycles, then gnt0 on cycle 17.
REQ-041 Bench SHALL cover: reset mid-operation; rst pulsed the cycle after a granted read on port 1 -> rvalid1 stays 0, FSM returns to IDLE, next contention grants port 0.
REQ-042 Bench SHALL cover: read-after-write across ports; port 1 writes 0x3C to 0xFF, then port 0 reads 0xFF -> rdata0=0x3C.
